// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the display data generator: FSM state encoding,
// front-panel mode one-hot codes, display tag nibbles, packing field
// positions and the duty-cycle saturation limit.
// -----------------------------------------------------------------------------
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      PACK  = 2'd3
   } state_t;

   localparam logic [3:0] BLANK_NIB = 4'hF;

   // Tag nibble shown in the leftmost display digit.
   localparam logic [3:0] TAG_F = 4'h1;
   localparam logic [3:0] TAG_T = 4'h2;
   localparam logic [3:0] TAG_Z = 4'h3;

   // mode_sel one-hot codes; every other pattern means blank.
   localparam logic [3:0] MODE_F = 4'b0001;
   localparam logic [3:0] MODE_T = 4'b0010;
   localparam logic [3:0] MODE_Z = 4'b0100;

   // disp_data layout: [31:28] tag, [27:20] filler, [19:0] five BCD digits.
   localparam int TAG_LSB  = 28;
   localparam int FILL_LSB = 20;
   localparam int DIG_BITS = 20;

   localparam logic [6:0] Z_MAX = 7'd100;

   // Tag for a latched mode; BLANK_NIB marks a blank (invalid) mode.
   function automatic logic [3:0] mode_tag(input logic [3:0] mode);
      case (mode)
         MODE_F:  mode_tag = TAG_F;
         MODE_T:  mode_tag = TAG_T;
         MODE_Z:  mode_tag = TAG_Z;
         default: mode_tag = BLANK_NIB;
      endcase
   endfunction

endpackage

// File: rtl/disp_data_gen_if.sv
// -----------------------------------------------------------------------------
// disp_data_gen_if
// Bus between the front-panel/controller side (master) and the display data
// generator (slave).
//   mode_sel  : 4-bit one-hot quantity select (F / T / Z, else blank)
//   F, T, Z   : 9/11/7-bit front-panel quantities
//   start     : single-cycle conversion request
//   busy      : conversion in progress
//   done      : one-cycle pulse when disp_data updates
//   disp_data : eight display nibbles for the digit scanner
//
// Handshake: start is a request strobe with no ready; it is sampled on every
// clk edge and never dropped (a request during a conversion is queued, and
// further requests merge with the queued one). done is a single-cycle pulse
// coincident with the new disp_data value; disp_data holds between pulses.
// -----------------------------------------------------------------------------
interface disp_data_gen_if;
   logic [3:0]  mode_sel;
   logic [8:0]  F;
   logic [10:0] T;
   logic [6:0]  Z;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] disp_data;

   modport master (
      output mode_sel, F, T, Z, start,
      input  busy, done, disp_data
   );

   modport slave (
      input  mode_sel, F, T, Z, start,
      output busy, done, disp_data
   );
endinterface

// File: rtl/disp_data_gen_bcd_dabble_core.sv
// -----------------------------------------------------------------------------
// bcd_dabble_core
// Iterative binary-to-BCD converter (shift-add-3). One iteration per i_step
// cycle: every BCD nibble >= 5 gets +3, then the whole {bcd, bin} register
// shifts left by one. After DATA_W iterations the BCD digits are valid.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   i_load   : start a new conversion with i_din (clears BCD and counter)
//   i_din    : binary value to convert
//   i_step   : perform one iteration (ignored once complete)
//   o_bcd    : DIGITS BCD digits, most significant first
//   o_last   : the iteration counter is on the final step
//   o_done   : all DATA_W iterations complete
// -----------------------------------------------------------------------------
module bcd_dabble_core #(
   parameter int DATA_W = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [DATA_W-1:0]     i_din,
   input  logic                  i_step,
   output logic [DIGITS*4-1:0]   o_bcd,
   output logic                  o_last,
   output logic                  o_done
);

   localparam int SR_W  = DIGITS*4 + DATA_W;
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [SR_W-1:0]  r_sr;
   logic [CNT_W-1:0] r_cnt;
   logic [SR_W-1:0]  w_adj;

   // Add-3 correction on the BCD part only; binary part passes through.
   always_comb begin
      w_adj = r_sr;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_sr[DATA_W + 4*i +: 4] >= 4'd5)
            w_adj[DATA_W + 4*i +: 4] = r_sr[DATA_W + 4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_sr  <= {{(DIGITS*4){1'b0}}, i_din};
         r_cnt <= '0;
      end else if (i_step && !o_done) begin
         r_sr  <= w_adj << 1;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_bcd  = r_sr[SR_W-1 -: DIGITS*4];
   assign o_last = (r_cnt == CNT_W'(DATA_W - 1));
   assign o_done = (r_cnt == CNT_W'(DATA_W));

endmodule

// File: rtl/disp_data_gen.sv
// -----------------------------------------------------------------------------
// disp_data_gen
// Produces the 32-bit disp_data word for the digit scanner. On a trigger
// (start or periodic refresh tick) it latches the quantity chosen by
// mode_sel, converts it to five BCD digits and packs tag + filler + digits.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : mode_sel, F, T, Z, start in; busy, done, disp_data out
//   o_dbg_state : current FSM state, for observation only
// Parameters:
//   DATA_W      : conversion width (inputs zero-extended to it)
//   DIGITS      : BCD digits, must be 5 to fit the packing layout
//   REFRESH_CYC : cycles between automatic conversions, 0 = no auto refresh
// Build option:
//   LZ_BLANK_EN : when defined, leading zero digits are shown as blank (4'hF);
//                 the least significant digit is always shown.
// -----------------------------------------------------------------------------
module disp_data_gen
   import disp_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int DIGITS      = 5,
   parameter int REFRESH_CYC = 5000000
) (
   input  logic            clk,
   input  logic            rst,
   disp_data_gen_if.slave  bus,
   output state_t          o_dbg_state
);

   state_t                r_state;
   state_t                w_next;
   logic                  r_pending;
   logic [3:0]            r_mode;
   logic [31:0]           r_disp;
   logic                  r_done;

   logic                  w_tick;
   logic                  w_trig;
   logic                  w_load;
   logic                  w_step;
   logic                  w_pack;
   logic                  w_busy;
   logic [DATA_W-1:0]     w_sel_val;
   logic [DIGITS*4-1:0]   w_bcd;
   logic [DIGITS*4-1:0]   w_digits;
   logic                  w_core_last;
   logic                  w_core_done;
   logic [3:0]            w_tag;
   logic [31:0]           w_packed;

   // ---------------------------------------------------------------- refresh
   localparam int CNT_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

   generate
      if (REFRESH_CYC == 0) begin : g_no_refresh
         assign w_tick = 1'b0;
      end else begin : g_refresh
         logic [CNT_W-1:0] r_ref_cnt;

         // Counts 0..REFRESH_CYC-1; the tick is the wrap cycle.
         always_ff @(posedge clk) begin
            if (rst || w_tick)
               r_ref_cnt <= '0;
            else
               r_ref_cnt <= r_ref_cnt + 1'b1;
         end

         assign w_tick = (r_ref_cnt == CNT_W'(REFRESH_CYC - 1));
      end
   endgenerate

   // start and a coincident tick collapse into a single trigger.
   assign w_trig = bus.start | w_tick;

   // ------------------------------------------------------------ input mux
   always_comb begin
      w_sel_val = '0;
      case (bus.mode_sel)
         MODE_F:  w_sel_val = DATA_W'(bus.F);
         MODE_T:  w_sel_val = DATA_W'(bus.T);
         MODE_Z:  w_sel_val = (bus.Z > Z_MAX) ? DATA_W'(Z_MAX) : DATA_W'(bus.Z);
         default: w_sel_val = '0;
      endcase
   end

   // ---------------------------------------------------------- BCD engine
   bcd_dabble_core #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_din  (w_sel_val),
      .i_step (w_step),
      .o_bcd  (w_bcd),
      .o_last (w_core_last),
      .o_done (w_core_done)
   );

   // ------------------------------------------------------- FSM: state reg
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // ------------------------------------------------------ FSM: next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (w_trig) w_next = LOAD;
         LOAD:  w_next = SHIFT;
         SHIFT: if (w_core_last) w_next = PACK;
         // A trigger landing in the PACK cycle itself is not yet in
         // r_pending, so it is honoured here directly.
         PACK:  w_next = (r_pending || w_trig) ? LOAD : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------- FSM: outputs
   always_comb begin
      w_load = 1'b0;
      w_step = 1'b0;
      w_pack = 1'b0;
      w_busy = 1'b0;
      case (r_state)
         LOAD:  w_load = 1'b1;
         SHIFT: begin
            w_step = 1'b1;
            w_busy = 1'b1;
         end
         PACK:  begin
            w_pack = w_core_done;
            w_busy = 1'b1;
         end
         default: ;
      endcase
   end

   // At most one extra conversion is queued; PACK consumes it.
   always_ff @(posedge clk) begin
      if (rst)
         r_pending <= 1'b0;
      else if (r_state == PACK)
         r_pending <= 1'b0;
      else if ((r_state == LOAD || r_state == SHIFT) && w_trig)
         r_pending <= 1'b1;
   end

   // --------------------------------------------------------------- packing
   always_comb begin
      w_digits = w_bcd;
`ifdef LZ_BLANK_EN
      begin
         logic lead;
         lead = 1'b1;
         for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (w_bcd[4*i +: 4] == 4'd0))
               w_digits[4*i +: 4] = BLANK_NIB;
            else
               lead = 1'b0;
         end
      end
`endif
   end

   assign w_tag = mode_tag(r_mode);

   always_comb begin
      w_packed = {8{BLANK_NIB}};
      if (w_tag != BLANK_NIB) begin
         w_packed[TAG_LSB +: 4]  = w_tag;
         w_packed[FILL_LSB +: 8] = {2{BLANK_NIB}};
         w_packed[0 +: DIG_BITS] = w_digits;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= '0;
         r_disp <= '1;
         r_done <= 1'b0;
      end else begin
         r_done <= w_pack;
         if (w_load) r_mode <= bus.mode_sel;
         if (w_pack) r_disp <= w_packed;
      end
   end

   assign bus.busy      = w_busy;
   assign bus.done      = r_done;
   assign bus.disp_data = r_disp;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_disp_data_gen.sv
// -----------------------------------------------------------------------------
// tb_disp_data_gen
// Directed bench for disp_data_gen. u_dut has auto refresh disabled and is
// driven by start; u_ref_dut uses REFRESH_CYC=100 and is never started.
// Expected words are hand computed; LZ_BLANK_EN selects the blanked forms.
// -----------------------------------------------------------------------------
module tb_disp_data_gen;
   import disp_pkg::*;

`ifdef LZ_BLANK_EN
   localparam bit LZ_EN = 1'b1;
`else
   localparam bit LZ_EN = 1'b0;
`endif

   logic   clk;
   logic   rst;
   logic   rst_r;
   state_t dbg_state;
   state_t dbg_state_r;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q[$];
   int          exp_t[$];

   disp_data_gen_if bus ();
   disp_data_gen_if rbus ();

   disp_data_gen #(.DATA_W(16), .DIGITS(5), .REFRESH_CYC(0)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   disp_data_gen #(.DATA_W(16), .DIGITS(5), .REFRESH_CYC(100)) u_ref_dut (
      .clk         (clk),
      .rst         (rst_r),
      .bus         (rbus),
      .o_dbg_state (dbg_state_r)
   );

   // ------------------------------------------------------- clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ checking
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] pick(input logic [31:0] plain, input logic [31:0] lz);
      return LZ_EN ? lz : plain;
   endfunction

   // ------------------------------------------------------------- drivers
   // One start-triggered conversion; checks latency, busy, data and hold.
   task automatic do_conv(input string name, input logic [3:0] m, input logic [8:0] f,
                          input logic [10:0] t, input logic [6:0] z, input logic [31:0] exp);
      int cyc;
      bus.mode_sel = m;
      bus.F        = f;
      bus.T        = t;
      bus.Z        = z;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 0;
      while (cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) chk({name, "_busy1"}, 32'(bus.busy), 32'd1);
         if (bus.done) break;
      end
      chk({name, "_lat"},   32'(cyc), 32'd18);
      chk({name, "_data"},  bus.disp_data, exp);
      chk({name, "_busy0"}, 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
      chk({name, "_hold"}, bus.disp_data, exp);
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      int n_done;
      rst           = 1'b1;
      rst_r         = 1'b1;
      bus.mode_sel  = 4'b0000;
      bus.F         = '0;
      bus.T         = '0;
      bus.Z         = '0;
      bus.start     = 1'b0;
      rbus.mode_sel = MODE_F;
      rbus.F        = 9'd10;
      rbus.T        = '0;
      rbus.Z        = '0;
      rbus.start    = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_data",  bus.disp_data, 32'hFFFF_FFFF);
      chk("rst_busy",  32'(bus.busy), 32'd0);
      chk("rst_done",  32'(bus.done), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk); #1;
      chk("idle_data", bus.disp_data, 32'hFFFF_FFFF);

      // ------------------------------------------------ directed vectors
      do_conv("f123",   MODE_F,  9'd123, 11'd0,    7'd0,   pick(32'h1FF0_0123, 32'h1FFF_F123));
      do_conv("t2047",  MODE_T,  9'd0,   11'd2047, 7'd0,   pick(32'h2FF0_2047, 32'h2FFF_2047));
      do_conv("z127",   MODE_Z,  9'd0,   11'd0,    7'd127, pick(32'h3FF0_0100, 32'h3FFF_F100));
      do_conv("z100",   MODE_Z,  9'd0,   11'd0,    7'd100, pick(32'h3FF0_0100, 32'h3FFF_F100));
      do_conv("z99",    MODE_Z,  9'd0,   11'd0,    7'd99,  pick(32'h3FF0_0099, 32'h3FFF_FF99));
      do_conv("z0",     MODE_Z,  9'd0,   11'd0,    7'd0,   pick(32'h3FF0_0000, 32'h3FFF_FFF0));
      do_conv("m1000",  4'b1000, 9'd77,  11'd5,    7'd5,   32'hFFFF_FFFF);
      do_conv("f511",   MODE_F,  9'd511, 11'd0,    7'd0,   pick(32'h1FF0_0511, 32'h1FFF_F511));
      do_conv("m0000",  4'b0000, 9'd77,  11'd5,    7'd5,   32'hFFFF_FFFF);
      do_conv("t1000",  MODE_T,  9'd0,   11'd1000, 7'd0,   pick(32'h2FF0_1000, 32'h2FFF_1000));
      do_conv("m0011",  4'b0011, 9'd1,   11'd1,    7'd1,   32'hFFFF_FFFF);
      do_conv("f0",     MODE_F,  9'd0,   11'd0,    7'd0,   pick(32'h1FF0_0000, 32'h1FFF_FFF0));

      // ---------------------- triggers while busy: one queued conversion
      exp_q.push_back(pick(32'h1FF0_0200, 32'h1FFF_F200));
      exp_t.push_back(18);
      exp_q.push_back(pick(32'h1FF0_0300, 32'h1FFF_F300));
      exp_t.push_back(36);
      bus.mode_sel = MODE_F;
      bus.F        = 9'd200;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_done = 0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            n_done++;
            if (exp_q.size() > 0) begin
               chk("pend_time", 32'(c), 32'(exp_t.pop_front()));
               chk("pend_data", bus.disp_data, exp_q.pop_front());
            end else begin
               chk("pend_extra_done", 32'(c), 32'd0);
            end
         end
         case (c)
            2:  bus.F = 9'd300;
            4:  bus.start = 1'b1;
            5:  bus.start = 1'b0;
            6:  bus.start = 1'b1;
            7:  bus.start = 1'b0;
            20: bus.F = 9'd400;
            default: ;
         endcase
      end
      chk("pend_count", 32'(n_done), 32'd2);
      chk("pend_idle",  32'(dbg_state), 32'(IDLE));

      // ------------------------------------------- reset during SHIFT
      bus.mode_sel = MODE_F;
      bus.F        = 9'd55;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_done = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (bus.done) n_done++;
         if (c == 8) begin
            chk("pre_rst_state", 32'(dbg_state), 32'(SHIFT));
            rst = 1'b1;
         end
         if (c == 9) begin
            rst = 1'b0;
            chk("abort_data",  bus.disp_data, 32'hFFFF_FFFF);
            chk("abort_busy",  32'(bus.busy), 32'd0);
            chk("abort_state", 32'(dbg_state), 32'(IDLE));
         end
      end
      chk("abort_no_done", 32'(n_done), 32'd0);
      do_conv("rst_recover", MODE_F, 9'd55, 11'd0, 7'd0, pick(32'h1FF0_0055, 32'h1FFF_FF55));

      // ------------------------------------------------ periodic refresh
      chk("ref_rst_data", rbus.disp_data, 32'hFFFF_FFFF);
      exp_q.push_back(pick(32'h1FF0_0010, 32'h1FFF_FF10));
      exp_t.push_back(118);
      exp_q.push_back(pick(32'h1FF0_0011, 32'h1FFF_FF11));
      exp_t.push_back(218);
      exp_q.push_back(pick(32'h1FF0_0011, 32'h1FFF_FF11));
      exp_t.push_back(318);
      rst_r  = 1'b0;
      n_done = 0;
      for (int c = 1; c <= 340; c++) begin
         @(posedge clk); #1;
         if (rbus.done) begin
            n_done++;
            if (exp_q.size() > 0) begin
               chk("ref_time", 32'(c), 32'(exp_t.pop_front()));
               chk("ref_data", rbus.disp_data, exp_q.pop_front());
            end else begin
               chk("ref_extra_done", 32'(c), 32'd0);
            end
            rbus.F = 9'd11;
         end
      end
      chk("ref_count", 32'(n_done), 32'd3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
